// File: rtl/aes_req_arbiter.sv
// aes_req_arbiter: shares one AES core between NREQ requesters with round-robin grant,
// a single-cycle START pulse, DONE rising-edge completion, a timeout guard and a per-requester response.
module aes_req_arbiter #(
   parameter int unsigned NREQ    = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NREQ-1:0]      REQ_VALID,
   output logic [NREQ-1:0]      REQ_READY,
   input  logic [NREQ-1:0]      REQ_ENCDEC,
   input  logic [128*NREQ-1:0]  REQ_KEY,
   input  logic [128*NREQ-1:0]  REQ_TEXT,
   output logic [NREQ-1:0]      RSP_VALID,
   input  logic [NREQ-1:0]      RSP_READY,
   output logic [127:0]         RSP_TEXT,
   output logic                 RSP_ERR,
   output logic                 CORE_START,
   output logic                 CORE_ENCDEC,
   output logic [127:0]         CORE_KEY,
   output logic [127:0]         CORE_TEXTIN,
   input  logic                 CORE_DONE,
   input  logic [127:0]         CORE_TEXTOUT
);
   localparam int unsigned GW = (NREQ > 2) ? 2 : 1;
   localparam int unsigned CW = 16;
   localparam int unsigned DW = 128;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t        r_state;
   state_t        w_next;
   logic [GW-1:0] r_last_grant;
   logic [GW-1:0] r_grant;
   logic [GW-1:0] w_grant;
   logic [GW-1:0] w_idx;
   logic          w_found;
   logic          w_accept;
   logic          w_done_rise;
   logic          w_timeout;
   logic          w_rsp_hs;
   logic [CW-1:0] r_cnt;
   logic          r_done_q;
   logic          r_encdec;
   logic          r_rsp_err;
   logic [DW-1:0] r_key;
   logic [DW-1:0] r_text;
   logic [DW-1:0] r_rsp_text;

   // Round-robin search: first valid requester after the last one served.
   always_comb begin
      w_grant = r_last_grant;
      w_found = 1'b0;
      w_idx   = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         w_idx = GW'((32'(r_last_grant) + i) % NREQ);
         if (!w_found && REQ_VALID[w_idx]) begin
            w_grant = w_idx;
            w_found = 1'b1;
         end
      end
   end

   assign w_accept    = (r_state == S_IDLE) && w_found;
   assign w_done_rise = CORE_DONE && !r_done_q;
   assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT));
   assign w_rsp_hs    = (r_state == S_RESP) && RSP_READY[r_grant];

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      REQ_READY  = '0;
      RSP_VALID  = '0;
      CORE_START = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               REQ_READY = NREQ'(1) << w_grant;
               w_next    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            CORE_START = 1'b1;
            w_next     = S_WAIT;
         end
         S_WAIT: begin
            if (w_done_rise || w_timeout) w_next = S_RESP;
         end
         S_RESP: begin
            RSP_VALID = NREQ'(1) << r_grant;
            if (w_rsp_hs) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Holding registers, wait counter and response capture; completion beats timeout.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_last_grant <= GW'(NREQ - 1);
         r_grant      <= '0;
         r_encdec     <= 1'b0;
         r_key        <= '0;
         r_text       <= '0;
         r_cnt        <= '0;
         r_done_q     <= 1'b0;
         r_rsp_text   <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         r_done_q <= CORE_DONE;
         if (w_accept) begin
            r_grant  <= w_grant;
            r_encdec <= REQ_ENCDEC[w_grant];
            r_key    <= REQ_KEY[{w_grant, 7'd0} +: DW];
            r_text   <= REQ_TEXT[{w_grant, 7'd0} +: DW];
         end
         if (r_state == S_ISSUE) begin
            r_cnt <= '0;
         end else if (r_state == S_WAIT && r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
         end
         if (r_state == S_WAIT) begin
            if (w_done_rise) begin
               r_rsp_text <= CORE_TEXTOUT;
               r_rsp_err  <= 1'b0;
            end else if (w_timeout) begin
               r_rsp_text <= '0;
               r_rsp_err  <= 1'b1;
            end
         end
         if (w_rsp_hs) r_last_grant <= r_grant;
      end
   end

   assign RSP_TEXT    = r_rsp_text;
   assign RSP_ERR     = r_rsp_err;
   assign CORE_ENCDEC = r_encdec;
   assign CORE_KEY    = r_key;
   assign CORE_TEXTIN = r_text;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// tb_aes_req_arbiter: directed stimulus with a queue-based response scoreboard and a
// behavioural AES core stub answering known FIPS-197 / SP800-38A vectors after a fixed latency.
module tb_aes_req_arbiter;
   localparam int unsigned NREQ = 2;
   localparam int unsigned TMO  = 8;
   localparam int          LAT  = 3;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] C2 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

   logic                 CLK = 1'b0;
   logic                 RST;
   logic [NREQ-1:0]      REQ_VALID, REQ_READY, REQ_ENCDEC, RSP_VALID, RSP_READY;
   logic [128*NREQ-1:0]  REQ_KEY, REQ_TEXT;
   logic [127:0]         RSP_TEXT, CORE_KEY, CORE_TEXTIN, CORE_TEXTOUT;
   logic                 RSP_ERR, CORE_START, CORE_ENCDEC, CORE_DONE;

   typedef struct { int idx; logic [127:0] text; logic err; } exp_t;
   exp_t sb[$];
   exp_t mon_e;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   stub_mode = 0;   // 0 normal, 1 DONE stuck low, 2 DONE stuck high
   logic         core_done_r, core_busy;
   int           core_cnt;
   logic [127:0] core_res;
   int t_acc, t_rv, n_st, t_st, t_rel, n_g;
   int grants[4];

   aes_req_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_ENCDEC(REQ_ENCDEC),
      .REQ_KEY(REQ_KEY), .REQ_TEXT(REQ_TEXT),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_TEXT(RSP_TEXT), .RSP_ERR(RSP_ERR),
      .CORE_START(CORE_START), .CORE_ENCDEC(CORE_ENCDEC), .CORE_KEY(CORE_KEY),
      .CORE_TEXTIN(CORE_TEXTIN), .CORE_DONE(CORE_DONE), .CORE_TEXTOUT(CORE_TEXTOUT)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [127:0] aes_ref(input logic ed, input logic [127:0] k, input logic [127:0] t);
      if (!ed && k == K1 && t == P1) return C1;
      if ( ed && k == K1 && t == C1) return P1;
      if (!ed && k == K2 && t == P2) return C2;
      if ( ed && k == K2 && t == C2) return P2;
      return {4{32'hdeadbeef}};
   endfunction

   // Core stub: DONE drops on START and rises LAT cycles later, then holds high.
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         core_done_r  <= 1'b0;
         core_busy    <= 1'b0;
         core_cnt     <= 0;
         core_res     <= '0;
         CORE_TEXTOUT <= '0;
      end else if (CORE_START) begin
         core_done_r <= 1'b0;
         core_busy   <= 1'b1;
         core_cnt    <= 0;
         core_res    <= aes_ref(CORE_ENCDEC, CORE_KEY, CORE_TEXTIN);
      end else if (core_busy) begin
         if (core_cnt == LAT - 1) begin
            core_busy    <= 1'b0;
            CORE_TEXTOUT <= core_res;
            if (stub_mode == 0) core_done_r <= 1'b1;
         end else begin
            core_cnt <= core_cnt + 1;
         end
      end
   end
   assign CORE_DONE = (stub_mode == 2) ? 1'b1 : core_done_r;

   // Monitor: one-hot checks every cycle; pops the scoreboard on each response handshake.
   always @(negedge CLK) begin
      if (!RST) begin
         check("req_ready_onehot0", 128'($countones(REQ_READY) <= 1), 128'(1));
         check("rsp_valid_onehot0", 128'($countones(RSP_VALID) <= 1), 128'(1));
         if ((RSP_VALID & RSP_READY) != '0) begin
            check("rsp_expected_pending", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
               mon_e = sb.pop_front();
               check("rsp_idx", 128'(RSP_VALID[1]), 128'(mon_e.idx));
               check("rsp_text", RSP_TEXT, mon_e.text);
               check("rsp_err", 128'(RSP_ERR), 128'(mon_e.err));
            end
         end
      end
   end

   task automatic push_exp(input int idx, input logic [127:0] t, input logic err);
      exp_t e;
      e.idx = idx; e.text = t; e.err = err;
      sb.push_back(e);
   endtask

   task automatic drive_req(input int r, input logic ed, input logic [127:0] k, input logic [127:0] t);
      REQ_ENCDEC[r]          = ed;
      REQ_KEY[128*r +: 128]  = k;
      REQ_TEXT[128*r +: 128] = t;
      REQ_VALID[r]           = 1'b1;
   endtask

   task automatic wait_accept(input int r, output int ta);
      ta = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         if (REQ_READY[r]) begin
            ta = cyc + 1;
            break;
         end
      end
      check("accept_seen", 128'(ta >= 0), 128'(1));
      if (ta >= 0) begin
         @(posedge CLK); #1;
         REQ_VALID[r] = 1'b0;
      end
   endtask

   task automatic wait_rsp(input int r, output int tr, output int ns, output int ts);
      tr = -1; ns = 0; ts = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (CORE_START) begin
            ns++;
            ts = cyc;
         end
         if (RSP_VALID[r]) begin
            tr = cyc;
            break;
         end
      end
      check("rsp_seen", 128'(tr >= 0), 128'(1));
   endtask

   task automatic do_op(input int r, input logic ed, input logic [127:0] k, input logic [127:0] t,
                        input logic [127:0] et, input logic ee, input int lat, input string tag);
      int ta, tr, ns, ts;
      push_exp(r, et, ee);
      drive_req(r, ed, k, t);
      wait_accept(r, ta);
      wait_rsp(r, tr, ns, ts);
      check({tag, "_latency"}, 128'(tr - ta), 128'(lat));
      check({tag, "_start_count"}, 128'(ns), 128'(1));
      check({tag, "_start_cycle"}, 128'(ts - ta), 128'(0));
      @(posedge CLK); #1;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_req_ready"},   128'(REQ_READY), 128'(0));
      check({tag, "_rsp_valid"},   128'(RSP_VALID), 128'(0));
      check({tag, "_rsp_err"},     128'(RSP_ERR), 128'(0));
      check({tag, "_core_start"},  128'(CORE_START), 128'(0));
      check({tag, "_core_encdec"}, 128'(CORE_ENCDEC), 128'(0));
      check({tag, "_rsp_text"},    RSP_TEXT, 128'(0));
      check({tag, "_core_key"},    CORE_KEY, 128'(0));
      check({tag, "_core_textin"}, CORE_TEXTIN, 128'(0));
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge CLK);
      check("scoreboard_drained", 128'(sb.size()), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; REQ_VALID = '0; REQ_ENCDEC = '0; REQ_KEY = '0; REQ_TEXT = '0; RSP_READY = '1;
      repeat (3) @(posedge CLK);
      #1;
      check_reset_vals("reset");
      RST = 1'b0;
      @(posedge CLK); #1;

      // Single requests
      do_op(0, 1'b0, K1, P1, C1, 1'b0, 5, "r0_enc");
      do_op(0, 1'b1, K1, C1, P1, 1'b0, 5, "r0_dec");
      do_op(1, 1'b0, K2, P2, C2, 1'b0, 5, "r1_enc");

      // Round-robin with both requesters held valid
      push_exp(0, C1, 1'b0); push_exp(1, C2, 1'b0);
      push_exp(0, C1, 1'b0); push_exp(1, C2, 1'b0);
      drive_req(0, 1'b0, K1, P1);
      drive_req(1, 1'b0, K2, P2);
      n_g = 0;
      for (int i = 0; i < 200 && n_g < 4; i++) begin
         @(negedge CLK);
         if (REQ_READY != '0) begin
            grants[n_g] = int'(REQ_READY[1]);
            n_g++;
            @(posedge CLK); #1;
            if (n_g == 4) REQ_VALID = '0;
         end
      end
      check("rr_grant_count", 128'(n_g), 128'(4));
      for (int i = 0; i < 4; i++) check($sformatf("rr_grant%0d", i), 128'(grants[i]), 128'(i % 2));
      drain();
      @(posedge CLK); #1;

      // Backpressure on requester 0 while requester 1 waits
      push_exp(0, C1, 1'b0);
      push_exp(1, P2, 1'b0);
      RSP_READY[0] = 1'b0;
      drive_req(0, 1'b0, K1, P1);
      wait_accept(0, t_acc);
      wait_rsp(0, t_rv, n_st, t_st);
      check("bp_latency", 128'(t_rv - t_acc), 128'(5));
      drive_req(1, 1'b1, K2, C2);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge CLK);
         check("bp_rsp_valid", 128'(RSP_VALID), 128'(2'b01));
         check("bp_rsp_text", RSP_TEXT, C1);
         check("bp_req_ready", 128'(REQ_READY), 128'(0));
         check("bp_core_start", 128'(CORE_START), 128'(0));
      end
      @(posedge CLK); #1;
      RSP_READY[0] = 1'b1;
      t_rel = cyc;
      wait_accept(1, t_acc);
      check("bp_accept_cycle", 128'(t_acc - t_rel), 128'(2));
      wait_rsp(1, t_rv, n_st, t_st);
      check("bp_r1_latency", 128'(t_rv - t_acc), 128'(5));
      @(posedge CLK); #1;
      drain();

      // Timeouts: DONE stuck low, then DONE held high across START
      stub_mode = 1;
      do_op(0, 1'b0, K1, P1, 128'(0), 1'b1, 10, "tmo_low");
      stub_mode = 2;
      do_op(0, 1'b0, K1, P1, 128'(0), 1'b1, 10, "tmo_high");
      stub_mode = 0;
      @(posedge CLK); #1;

      // Reset in WAIT, then a clean operation
      drive_req(0, 1'b0, K1, P1);
      wait_accept(0, t_acc);
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      RST = 1'b1;
      #1;
      check_reset_vals("rst_wait");
      @(posedge CLK); #1;
      RST = 1'b0;
      @(posedge CLK); #1;
      do_op(0, 1'b0, K1, P1, C1, 1'b0, 5, "post_rst");
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_req_arbiter.md
# aes_req_arbiter

Round-robin arbiter and sequencer that shares one `AES_Crypto_Processor` instance between `NREQ` requesters. Each requester presents key, text and direction with a valid/ready handshake. The block latches one request, pulses the core's `START`, waits for `DONE` (with a timeout guard), and returns `TEXTOUT` on that requester's response channel. It sits between the bus-side clients and the AES core, and is the only driver of the core's `START`/`ENCDEC`/`KEY`/`TEXTIN`.

## Interface
Parameters:
- `NREQ`, 2, number of requesters (2..4).
- `TIMEOUT`, 255, maximum number of WAIT cycles before the request is aborted; 0 disables the timeout.

Ports:
- `CLK`  in  1  single clock; all flops rise-edge.
- `RST`  in  1  asynchronous, active-high reset.
- `REQ_VALID`  in  NREQ  per-requester request valid.
- `REQ_READY`  out  NREQ  per-requester accept; one-hot or zero.
- `REQ_ENCDEC`  in  NREQ  per-requester direction: 0 = encrypt, 1 = decrypt.
- `REQ_KEY`  in  128*NREQ  requester i occupies bits [128i+127:128i].
- `REQ_TEXT`  in  128*NREQ  requester i occupies bits [128i+127:128i].
- `RSP_VALID`  out  NREQ  per-requester response valid; one-hot or zero.
- `RSP_READY`  in  NREQ  per-requester response accept.
- `RSP_TEXT`  out  128  shared response data; qualified by `RSP_VALID`.
- `RSP_ERR`  out  1  1 = timeout occurred and `RSP_TEXT` is all zeros.
- `CORE_START`  out  1  to core `START`.
- `CORE_ENCDEC`  out  1  to core `ENCDEC`.
- `CORE_KEY`  out  128  to core `KEY`.
- `CORE_TEXTIN`  out  128  to core `TEXTIN`.
- `CORE_DONE`  in  1  from core `DONE`.
- `CORE_TEXTOUT`  in  128  from core `TEXTOUT`.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - The grant goes to the first requester with `REQ_VALID` set, searching from `last_grant+1` modulo `NREQ`.
  - `REQ_READY[grant]` is driven combinationally while in IDLE and while any `REQ_VALID` is set.
  - On the handshake, the block latches key, text, encdec and the grant index into holding registers and moves to ISSUE.
- **ISSUE:** `CORE_START` = 1 for exactly this one cycle, then the FSM moves to WAIT. The wait counter clears to 0.
- **WAIT:**
  - The counter increments every cycle.
  - A completion is a rising edge of `CORE_DONE`, i.e. `CORE_DONE=1` while the registered `done_q=0`. A `DONE` level still held high from a previous operation is ignored.
  - On completion: latch `CORE_TEXTOUT` into `RSP_TEXT`, set `RSP_ERR`=0, and move to RESP.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT` with no completion: `RSP_TEXT`=0, `RSP_ERR`=1, move to RESP.
  - If completion and timeout occur in the same cycle, completion wins.
- **RESP:**
  - `RSP_VALID[grant]`=1, held with stable data until `RSP_READY[grant]`=1.
  - On that handshake: `last_grant`←grant, then return to IDLE.
  - `RSP_READY` bits of other requesters are ignored.
- `CORE_KEY`, `CORE_TEXTIN` and `CORE_ENCDEC` come straight from the holding registers. They are stable from ISSUE through RESP.
- While the block is busy (ISSUE, WAIT, RESP), no new request is accepted and `REQ_READY`=0.
- The wait counter is 16 bits wide and saturates rather than wrapping.

## Timing
- Reset values:
  - `REQ_READY`, `RSP_VALID`, `RSP_ERR`, `CORE_START`, `CORE_ENCDEC` = 0.
  - `RSP_TEXT`, `CORE_KEY`, `CORE_TEXTIN` = 0.
  - FSM = IDLE, counter = 0, `done_q` = 0.
  - `last_grant` = `NREQ-1`, so requester 0 has priority first.
- Request handshake at edge T: `CORE_START` is high during cycle T+1. WAIT begins at T+2.
- `CORE_DONE` rising edge sampled at edge D: `RSP_VALID` is high from D+1.
- Response handshake at edge R: the FSM is in IDLE at R+1, so the earliest next accept is at edge R+1.
- Best-case throughput is one operation per (core latency + 4) cycles.
- **Reset mid-operation:** return immediately to IDLE. No response is produced for the in-flight request, and `CORE_START` and `RSP_VALID` drop asynchronously.
  - The system ties the core's `nRST` to `~RST`, so no stale `DONE` edge survives a reset.
- **Simultaneous requests:** requesters are served strictly round-robin. With all requesters held valid, each is served once per `NREQ` operations and none starves.
- A requester that drops `REQ_VALID` before it is accepted is simply skipped. No state is kept for it.

## Test plan
- **Single request, requester 0:**
  - Stimulus: encrypt with key 000102030405060708090a0b0c0d0e0f, text 00112233445566778899aabbccddeeff.
  - Response: `RSP_VALID[0]` with `RSP_TEXT`=69c4e0d86a7b0430d8cdb78070b4c55a and `RSP_ERR`=0.
  - Then decrypt that result: `RSP_TEXT` returns the original plaintext.
- **Requester 1:**
  - Stimulus: encrypt with key 2b7e151628aed2a6abf7158809cf4f3c, text 6bc1bee22e409f96e93d7e117393172a.
  - Response: `RSP_VALID[1]` with `RSP_TEXT`=3ad77bb40d7a3660a89ecaf32466ef97.
  - `CORE_START` is high exactly one cycle, at accept+1.
- **Round-robin:** both `REQ_VALID` held high for 4 operations.
  - Grant order is 0,1,0,1.
  - `REQ_READY` is never two-hot, and `RSP_VALID` goes to the matching index each time.
- **Backpressure:** `RSP_READY` held low for 5 cycles after `RSP_VALID` rises.
  - `RSP_VALID` and `RSP_TEXT` stay stable.
  - `REQ_READY`=0 and `CORE_START` stays 0 throughout.
  - Accept occurs on the cycle after `RSP_READY` rises.
- **Timeout:** `TIMEOUT`=8 with a stub core that holds `CORE_DONE` at 0.
  - `RSP_VALID` rises 9 cycles after WAIT entry, with `RSP_ERR`=1 and `RSP_TEXT`=0.
  - Repeat with `DONE` held high from before START: this also times out, because it is not a rising edge.
- **Reset in WAIT:** assert `RST` for 1 cycle mid-WAIT.
  - All outputs are at their reset values immediately.
  - The next request from requester 0 completes correctly.
